seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector. It watches a 1-bit input stream for a run-time programmable bit pattern of 1..MAX_LEN bits, in overlapping or non-overlapping mode. It raises a one-cycle Moore-style detect flag and keeps a saturating match count. It replaces fixed-pattern hard-coded detector FSMs wherever a serial stream needs pattern matching.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of the pattern-length port.
- CNT_W, 8: match counter width.

- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- IN  in  1  serial data bit, sampled when EN=1.
- EN  in  1  sample enable.
- PAT_LOAD  in  1  load PAT/PAT_LEN/OVERLAP this cycle.
- PAT  in  MAX_LEN  pattern; PAT[PAT_LEN-1] is the first-arriving bit, PAT[0] the last.
- PAT_LEN  in  LEN_W  pattern length.
- OVERLAP  in  1  1 = overlapping matches allowed.
- CNT_CLR  in  1  clear match counter.
- DET  out  1  match detected (registered).
- MATCH_CNT  out  CNT_W  saturating match count.
- CFG_ERR  out  1  one-cycle pulse: load rejected.
- ARMED  out  1  valid pattern loaded.

## Operation
- FSM states:
  - UNCFG: entered on reset. IN is ignored and DET=0.
  - RUN: detecting.
- UNCFG→RUN: on a valid load.
- RUN→RUN: a reload replaces the configuration.
- No path back to UNCFG except RST.
- Valid load: PAT_LOAD=1 and 1 ≤ PAT_LEN ≤ MAX_LEN. On a valid load the block:
  - latches PAT, PAT_LEN and OVERLAP;
  - clears the history register and the fill counter;
  - forces DET=0 next cycle.
- Invalid load (PAT_LEN=0 or >MAX_LEN):
  - CFG_ERR=1 for one cycle;
  - configuration, state and history are unchanged.
- History: MAX_LEN-bit shift register, shifting left with IN entering at bit 0, on each cycle with EN=1 and no PAT_LOAD.
- Fill counter: counts accepted bits, saturating at MAX_LEN.
- Match condition: the next history value, masked to its low PAT_LEN bits, equals PAT masked the same way, AND next fill ≥ PAT_LEN.
- On a match:
  - DET=1 next cycle;
  - MATCH_CNT increments, saturating at 2^CNT_W-1, with no wrap.
- Non-overlap mode: on a match the fill counter resets to 0, so the matched bits cannot contribute to the next match.
- Overlap mode: the fill counter is untouched.
- EN=0: history, fill and counter hold; DET=0.
- Priorities, highest first: RST > PAT_LOAD > sample.
  - A bit presented together with PAT_LOAD is discarded.
  - CNT_CLR together with a match: counter becomes 0 (the match is not counted) and DET still asserts.
- Reset values: DET=0, MATCH_CNT=0, CFG_ERR=0, ARMED=0. History, fill and stored pattern are all 0; state is UNCFG.

## Timing
- Latency: the final pattern bit is sampled at edge N, and DET is high from edge N until edge N+1.
- DET never stays high more than one cycle per accepted bit.
- Back-to-back DET in consecutive cycles is legal in overlap mode (e.g. PAT_LEN=1, or pattern "11" on input 111).
- MATCH_CNT updates on the same edge that DET rises.
- ARMED rises on the edge after the first valid load.
- CFG_ERR is registered and occurs one cycle after the rejected load.
- RST mid-stream: on the next edge all state returns to reset values and the pattern must be reloaded.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/include holds:
  - the FSM state encodings (ST_UNCFG, ST_RUN);
  - a LEN_W helper function;
  - the default MAX_LEN/CNT_W constants.
- One natural sub-module, `sat_counter`: a CNT_W-bit saturating counter with clear and increment. It is reusable elsewhere.
- Everything else is flat: config registers, history shift register, mask/compare logic and the FSM.

## Test plan
- Overlap mode:
  - Stimulus: load PAT=4'b1011, PAT_LEN=4, OVERLAP=1, then stream 1,0,1,1,0,1,1.
  - Response: DET high after bits 4 and 7; MATCH_CNT=2.
- Non-overlap mode:
  - Stimulus: same pattern with OVERLAP=0, stream 1,0,1,1,0,1,1.
  - Response: DET only after bit 4; MATCH_CNT=1.
- Invalid load then reload mid-stream:
  - Stimulus: PAT_LEN=0 load.
  - Response: CFG_ERR pulse, ARMED stays 0, and stream 1011 gives no DET.
  - Stimulus: valid load of 3'b110 after feeding 1,1.
  - Response: the 1,1 history is discarded, and 1,1,0 is needed for DET.
- Saturation and clear:
  - Stimulus: CNT_W=2, PAT=1'b1, PAT_LEN=1, overlap, stream 5 ones.
  - Response: DET high 5 consecutive cycles and MATCH_CNT=3.
  - Stimulus: CNT_CLR coincident with the next match.
  - Response: MATCH_CNT=0 with DET=1.
- EN gating and mid-run reset:
  - Stimulus: stream 1,0,(EN=0 for 3 cycles with IN=0),1,1.
  - Response: one DET.
  - Stimulus: assert RST after bit 3 of a 4-bit pattern.
  - Response: all outputs 0, and no DET on the following bit.
- Full-length pattern:
  - Stimulus: PAT_LEN=MAX_LEN=8, PAT=8'hA5, stream A5 MSB-first.
  - Response: DET after bit 8 only, not before the fill count reaches 8.

Source files
------------

// File: rtl/seq_detect_param_pkg.sv
// Shared definitions for the serial pattern detector: FSM encodings,
// default sizing constants and the pattern-length width helper.
package seq_detect_param_pkg;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 8;

  typedef enum logic [0:0] {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Bits needed to hold any length from 0 up to max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Reusable saturating up-counter with synchronous clear; clear beats increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_r;

  // Count register: reset, clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/seq_detect_param.sv
// Run-time programmable serial pattern detector with overlap control,
// one-cycle registered detect flag and a saturating match count.
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = len_width(MAX_LEN),
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN,
  input  logic               EN,
  input  logic               PAT_LOAD,
  input  logic [MAX_LEN-1:0] PAT,
  input  logic [LEN_W-1:0]   PAT_LEN,
  input  logic               OVERLAP,
  input  logic               CNT_CLR,
  output logic               DET,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic               CFG_ERR,
  output logic               ARMED
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state_r, state_next_s;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   pat_len_r;
  logic               overlap_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               det_r;
  logic               cfg_err_r;
  logic               armed_r;

  logic               len_ok_s;
  logic               good_load_s;
  logic               bad_load_s;
  logic               sample_s;
  logic [MAX_LEN-1:0] hist_next_s;
  logic [LEN_W-1:0]   fill_next_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               match_s;

  // Load qualification and the candidate next history/fill for this cycle.
  always_comb begin
    len_ok_s     = (PAT_LEN != '0) && (PAT_LEN <= LEN_MAX);
    good_load_s  = PAT_LOAD && len_ok_s;
    bad_load_s   = PAT_LOAD && !len_ok_s;
    sample_s     = EN && !PAT_LOAD && (state_r == ST_RUN);
    hist_next_s  = {hist_r[MAX_LEN-2:0], IN};
    if (fill_r == LEN_MAX) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + LEN_W'(1);
    end
  end

  // Compare only the low PAT_LEN bits, and only once enough bits have arrived.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < pat_len_r);
    end
    if (sample_s && ((hist_next_s & mask_s) == (pat_r & mask_s)) &&
        (fill_next_s >= pat_len_r)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // FSM next state: only a valid load leaves UNCFG, only RST returns to it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_UNCFG: begin
        if (good_load_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_UNCFG;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_UNCFG;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_UNCFG;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Configuration, history, fill and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_r     <= '0;
      pat_len_r <= '0;
      overlap_r <= 1'b0;
      hist_r    <= '0;
      fill_r    <= '0;
      det_r     <= 1'b0;
      cfg_err_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      det_r     <= match_s;
      cfg_err_r <= bad_load_s;
      armed_r   <= (state_next_s == ST_RUN);
      if (good_load_s) begin
        pat_r     <= PAT;
        pat_len_r <= PAT_LEN;
        overlap_r <= OVERLAP;
        hist_r    <= '0;
        fill_r    <= '0;
      end else if (sample_s) begin
        hist_r <= hist_next_s;
        // Non-overlap: matched bits may not seed the next match.
        fill_r <= (match_s && !overlap_r) ? '0 : fill_next_s;
      end else begin
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (CNT_CLR),
    .inc   (match_s),
    .count (MATCH_CNT)
  );

  assign DET     = det_r;
  assign CFG_ERR = cfg_err_r;
  assign ARMED   = armed_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Table-driven bench with an expected-output queue for seq_detect_param
// (MAX_LEN=8, CNT_W=2 so saturation is reachable quickly).
module tb_seq_detect_param;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN = 1'b0;
  logic       EN = 1'b0;
  logic       PAT_LOAD = 1'b0;
  logic [7:0] PAT = 8'h00;
  logic [3:0] PAT_LEN = 4'd0;
  logic       OVERLAP = 1'b0;
  logic       CNT_CLR = 1'b0;
  logic       DET;
  logic [1:0] MATCH_CNT;
  logic       CFG_ERR;
  logic       ARMED;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst, en, in_bit, ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov, clr;
    logic       edet;
    logic [1:0] ecnt;
    logic       eerr, earm;
  } vec_t;

  typedef struct {
    logic       det;
    logic [1:0] cnt;
    logic       err, arm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   step_no = 0;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN        (IN),
    .EN        (EN),
    .PAT_LOAD  (PAT_LOAD),
    .PAT       (PAT),
    .PAT_LEN   (PAT_LEN),
    .OVERLAP   (OVERLAP),
    .CNT_CLR   (CNT_CLR),
    .DET       (DET),
    .MATCH_CNT (MATCH_CNT),
    .CFG_ERR   (CFG_ERR),
    .ARMED     (ARMED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, expv);
    end
  endtask

  // Drive one cycle, queue its expected outputs, then check after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge CLK);
    RST      = v.rst;
    EN       = v.en;
    IN       = v.in_bit;
    PAT_LOAD = v.ld;
    PAT      = v.pat;
    PAT_LEN  = v.len;
    OVERLAP  = v.ov;
    CNT_CLR  = v.clr;
    sb.push_back('{det: v.edet, cnt: v.ecnt, err: v.eerr, arm: v.earm});
    @(posedge CLK);
    #1;
    step_no++;
    e = sb.pop_front();
    chk("DET",       {7'd0, DET},       {7'd0, e.det});
    chk("MATCH_CNT", {6'd0, MATCH_CNT}, {6'd0, e.cnt});
    chk("CFG_ERR",   {7'd0, CFG_ERR},   {7'd0, e.err});
    chk("ARMED",     {7'd0, ARMED},     {7'd0, e.arm});
  endtask

  task automatic mk(output vec_t v,
                    input logic rst, en, in_bit, ld, input logic [7:0] pat,
                    input logic [3:0] len, input logic ov, clr,
                    input logic edet, input logic [1:0] ecnt, input logic eerr, earm);
    v.rst = rst; v.en = en; v.in_bit = in_bit; v.ld = ld; v.pat = pat;
    v.len = len; v.ov = ov; v.clr = clr; v.edet = edet; v.ecnt = ecnt;
    v.eerr = eerr; v.earm = earm;
  endtask

  task automatic add(input logic rst, en, in_bit, ld, input logic [7:0] pat,
                     input logic [3:0] len, input logic ov, clr,
                     input logic edet, input logic [1:0] ecnt, input logic eerr, earm);
    vec_t v;
    mk(v, rst, en, in_bit, ld, pat, len, ov, clr, edet, ecnt, eerr, earm);
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, en, in_bit, ld, input logic [7:0] pat,
                      input logic [3:0] len, input logic ov, clr,
                      input logic edet, input logic [1:0] ecnt, input logic eerr, earm);
    vec_t v;
    mk(v, rst, en, in_bit, ld, pat, len, ov, clr, edet, ecnt, eerr, earm);
    apply(v);
  endtask

  initial begin
    logic [7:0] a5;
    //   rst en in ld pat    len ov clr | det cnt err arm
    add(1, 0, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);   // reset
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);   // unconfigured, input ignored
    add(0, 1, 1, 1, 8'h0B, 4'd0, 1, 0,  0, 2'd0, 1, 0);   // PAT_LEN=0 rejected
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);
    add(0, 0, 0, 1, 8'h0B, 4'd9, 1, 0,  0, 2'd0, 1, 0);   // PAT_LEN>MAX_LEN rejected
    // overlap 1011, bit on load cycle discarded
    add(0, 1, 1, 1, 8'h0B, 4'd4, 1, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd2, 0, 1);
    add(0, 0, 0, 0, 8'h00, 4'd0, 0, 1,  0, 2'd0, 0, 1);   // clear
    // non-overlap 1011
    add(0, 0, 0, 1, 8'h0B, 4'd4, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    // feed 1,1 then reload 110: history discarded
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 1, 8'h06, 4'd3, 1, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  1, 2'd2, 0, 1);
    // PAT=1 len 1 overlap: saturation then clear-with-match
    add(0, 0, 0, 1, 8'h01, 4'd1, 1, 1,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd2, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd3, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd3, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd3, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 1,  1, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd1, 0, 1);
    add(0, 0, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    // EN gating with 1011
    add(0, 0, 0, 1, 8'h0B, 4'd4, 1, 1,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  1, 2'd1, 0, 1);
    // mid-run reset after 3 bits of 1011
    add(0, 0, 0, 1, 8'h0B, 4'd4, 1, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd1, 0, 1);
    add(1, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 4'd0, 0, 0,  0, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Full-length pattern A5, MSB first: detect on the 8th bit only.
    a5 = 8'hA5;
    step(0, 0, 0, 1, 8'hA5, 4'd8, 0, 0,  0, 2'd0, 0, 1);
    for (int i = 7; i >= 0; i--) begin
      step(0, 1, a5[i], 0, 8'h00, 4'd0, 0, 0,
           (i == 0), (i == 0) ? 2'd1 : 2'd0, 0, 1);
    end

    // All-zero 8-bit pattern on cleared history: fill gate holds until bit 8.
    step(0, 0, 0, 1, 8'h00, 4'd8, 1, 1,  0, 2'd0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1'b0, 0, 8'h00, 4'd0, 0, 0,
           (i == 7), (i == 7) ? 2'd1 : 2'd0, 0, 1);
    end
    step(0, 1, 0, 0, 8'h00, 4'd0, 0, 0,  1, 2'd2, 0, 1);

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
